// File: rtl/turn_pkg.sv
// Shared definitions for the turn-signal sequencer: state width, state codes
// and small request-decoding helpers. Also consumed by the output-logic decoder.
`timescale 1ns/1ps

package turn_pkg;

    localparam int STATE_W = 3;

    // Codes 5..7 are unused and must be steered back to IDLE.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        HAZ  = 3'd4
    } state_e;

    // Exactly one of left/right requested.
    function automatic logic is_single_req(input logic [1:0] req);
        return req[0] ^ req[1];
    endfunction

    // Both left and right requested at once.
    function automatic logic is_hazard_req(input logic [1:0] req);
        return &req;
    endfunction

endpackage

// File: rtl/turn_seq_fsm_if.sv
// Bundle of the sequencer's switch input and status outputs, for benches and
// neighbouring blocks that want to pass the whole group around as one port.
`timescale 1ns/1ps

interface turn_seq_fsm_if;
    import turn_pkg::*;

    logic [1:0]         SW;
    logic [STATE_W-1:0] CurrentState;
    logic               turn_side;
    logic               step_tick;

    // Master drives the switches and observes the sequencer.
    modport master (output SW, input CurrentState, input turn_side, input step_tick);
    // Slave is the sequencer itself.
    modport slave  (input SW, output CurrentState, output turn_side, output step_tick);

endinterface

// File: rtl/tick_gen.sv
// Step-rate generator: free-running counter 0..TICK_DIV-1 and a registered
// one-cycle pulse that is high exactly while the counter holds TICK_DIV-1.
`timescale 1ns/1ps

module tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic Rn,
    output logic tick
);

    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 2);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Free-running divider counter, wraps to 0 after LAST.
    always_ff @(posedge clk or negedge Rn) begin
        if (!Rn) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Pulse is set on the same edge the counter moves to LAST, so it is a
    // flop output yet still coincides exactly with the LAST count.
    always_ff @(posedge clk or negedge Rn) begin
        if (!Rn) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == PRE_LAST);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/turn_seq_fsm.sv
// Turn-signal sequencer: synchronizes the left/right switches, then on each
// step pulse walks IDLE -> S1 -> S2 -> S3 -> IDLE for a single request,
// latching the direction only when a sequence starts from IDLE.
// Optional macro TURN_HAZARD_EN: both requests together enter HAZ, which
// returns to IDLE on the following step (blink while held). Without it,
// both requests act as no request and the HAZ logic is not built.
`timescale 1ns/1ps

module turn_seq_fsm
    import turn_pkg::*;
#(
    parameter int TICK_DIV = 25000000
) (
    input  logic               clk,
    input  logic               Rn,
    input  logic [1:0]         SW,
    output logic [STATE_W-1:0] CurrentState,
    output logic               turn_side,
    output logic               step_tick
);

    logic [1:0] r_sw_meta;
    logic [1:0] r_sw_sync;
    state_e     r_state;
    state_e     w_state_next;
    logic       r_side;
    logic       w_side_next;
    logic       w_tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .Rn   (Rn),
        .tick (w_tick)
    );

    // Two-flop synchronizer for the asynchronous switch inputs.
    // NOTE: clocked blocks use non-blocking (<=) so every flop samples the
    // pre-edge value of its source; blocking here would collapse the two
    // synchronizer stages into one.
    always_ff @(posedge clk or negedge Rn) begin
        if (!Rn) begin
            r_sw_meta <= 2'b00;
            r_sw_sync <= 2'b00;
        end else begin
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
        end
    end

    // State and latched direction update only on a step edge.
    always_ff @(posedge clk or negedge Rn) begin
        if (!Rn) begin
            r_state <= IDLE;
            r_side  <= 1'b0;
        end else if (w_tick) begin
            r_state <= w_state_next;
            r_side  <= w_side_next;
        end
    end

    // Next-state and next-direction decode from the synchronized requests.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // branch can leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_side_next  = r_side;

        case (r_state)
            IDLE: begin
                if (is_single_req(r_sw_sync)) begin
                    w_state_next = S1;
                    w_side_next  = r_sw_sync[1];
                end else begin
                    w_state_next = IDLE;
                end
            end
            S1:      w_state_next = S2;
            S2:      w_state_next = S3;
            S3:      w_state_next = IDLE;
`ifdef TURN_HAZARD_EN
            HAZ:     w_state_next = IDLE;
`endif
            default: w_state_next = IDLE;
        endcase

`ifdef TURN_HAZARD_EN
        // Hazard overrides any single-request move from a valid sequence
        // state; direction is left untouched.
        if (is_hazard_req(r_sw_sync) &&
            (r_state == IDLE || r_state == S1 || r_state == S2 || r_state == S3)) begin
            w_state_next = HAZ;
            w_side_next  = r_side;
        end
`endif
    end

    assign CurrentState = r_state;
    assign turn_side    = r_side;
    assign step_tick    = w_tick;

endmodule

// File: tb/tb_turn_seq_fsm.sv
// Bench for turn_seq_fsm with TICK_DIV=4. Stimulus changes the switches right
// after a step edge and pushes the reference model's expected outcome of the
// next step into a scoreboard; a monitor pops and compares after every step.
`timescale 1ns/1ps

module tb_turn_seq_fsm;
    import turn_pkg::*;

    localparam int TICK_DIV = 4;
`ifdef TURN_HAZARD_EN
    localparam bit HAZ_EN = 1'b1;
`else
    localparam bit HAZ_EN = 1'b0;
`endif

    typedef struct {
        int   st;
        logic side;
    } exp_t;

    logic clk = 1'b0;
    logic Rn;

    turn_seq_fsm_if bus ();

    turn_seq_fsm #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk          (clk),
        .Rn           (Rn),
        .SW           (bus.SW),
        .CurrentState (bus.CurrentState),
        .turn_side    (bus.turn_side),
        .step_tick    (bus.step_tick)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    int   m_state  = 0;   // 0 idle, 1..3 blink sequence position, 4 hazard
    logic m_side   = 1'b0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: apply the request level seen at the next step, then
    // queue the resulting state/direction.
    task automatic plan(input logic [1:0] sw);
        bus.SW = sw;
        if (m_state == 4) begin
            m_state = 0;
        end else if (sw == 2'b11 && HAZ_EN) begin
            m_state = 4;
        end else if (m_state != 0) begin
            m_state = (m_state + 1) % 4;
        end else if (sw == 2'b01 || sw == 2'b10) begin
            m_state = 1;
            m_side  = sw[1];
        end
        sb.push_back('{st: m_state, side: m_side});
    endtask

    // Monitor: after each step edge, compare against the scoreboard head;
    // also check the spacing between step pulses.
    bit   prev_tick = 1'b0;
    bit   have_tick = 1'b0;
    int   gap       = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_tick = 1'b0;
            have_tick = 1'b0;
            gap       = 0;
        end else begin
            if (prev_tick) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("step_state", int'(bus.CurrentState), mon_e.st);
                    check("step_side", int'(bus.turn_side), int'(mon_e.side));
                end
            end
            gap++;
            if (bus.step_tick) begin
                if (have_tick) check("tick_period", gap, TICK_DIV);
                have_tick = 1'b1;
                gap       = 0;
            end
            prev_tick = bus.step_tick;
        end
    end

    // Wait (bounded) for the next step edge; return 1 ns after it.
    task automatic wait_step();
        bit found = 1'b0;
        for (int i = 0; i < 3 * TICK_DIV && !found; i++) begin
            @(negedge clk);
            found = bus.step_tick;
        end
        check("step_seen", int'(found), 1);
        @(posedge clk);
        #1;
    endtask

    // Release reset mid low-phase and measure how many clock edges pass
    // before the first pulse: the counter reaches TICK_DIV-1 on the
    // (TICK_DIV-1)th edge, i.e. the pulse sits in the TICK_DIV-th cycle.
    task automatic release_reset(input string name);
        int edges = 0;
        bit seen  = 1'b0;
        @(negedge clk);
        #1;
        Rn     = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 4 * TICK_DIV && !seen; i++) begin
            @(negedge clk);
            edges++;
            seen = bus.step_tick;
        end
        check(name, edges, TICK_DIV - 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] rnd;

        // Reset state.
        Rn     = 1'b1;
        bus.SW = 2'b00;
        #1 Rn  = 1'b0;
        #7;
        check("rst_state", int'(bus.CurrentState), 0);
        check("rst_side", int'(bus.turn_side), 0);
        check("rst_tick", int'(bus.step_tick), 0);

        plan(2'b00);
        release_reset("first_tick_edges");

        // Left request held: 1,2,3,0,1,2,3,0.
        repeat (8) begin
            plan(2'b01);
            wait_step();
        end

        // Right start, then direction flips mid-sequence.
        repeat (2) begin
            plan(2'b10);
            wait_step();
        end
        repeat (3) begin
            plan(2'b01);
            wait_step();
        end
        repeat (3) begin
            plan(2'b00);
            wait_step();
        end

        // Both requests from S1.
        plan(2'b01);
        wait_step();
        repeat (4) begin
            plan(2'b11);
            wait_step();
        end
        plan(2'b00);
        wait_step();

        // One-cycle pulse well before the step window: filtered out.
        plan(2'b00);
        bus.SW = 2'b01;
        @(posedge clk);
        #1 bus.SW = 2'b00;
        wait_step();

        // Request raised inside the 2-cycle window: seen one step later.
        plan(2'b00);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 bus.SW = 2'b01;
        wait_step();
        plan(2'b01);
        wait_step();
        repeat (3) begin
            plan(2'b00);
            wait_step();
        end

        // Randomized request levels.
        repeat (40) begin
            rnd = 2'($urandom_range(0, 3));
            plan(rnd);
            wait_step();
        end
        repeat (4) begin
            plan(2'b00);
            wait_step();
        end

        // Reset in S2.
        plan(2'b01);
        wait_step();
        plan(2'b01);
        wait_step();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        Rn     = 1'b0;
        #1;
        check("midrst_state", int'(bus.CurrentState), 0);
        check("midrst_side", int'(bus.turn_side), 0);
        check("midrst_tick", int'(bus.step_tick), 0);
        check("midrst_sb_empty", sb.size(), 0);
        sb.delete();
        m_state = 0;
        m_side  = 1'b0;
        plan(2'b01);
        release_reset("restart_tick_edges");
        repeat (3) begin
            plan(2'b00);
            wait_step();
        end
        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/turn_seq_fsm.md
TURN_SEQ_FSM -- requirements
Module: turn_seq_fsm

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, clk cycles per sequencer step (min 2).
REQ-002 SHALL have port clk  input  1  system clock, all flops rising-edge.
REQ-003 SHALL have port Rn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port SW  input  2  raw switches; SW[0] left request, SW[1] right request; asynchronous to clk.
REQ-005 SHALL have port CurrentState  output  3  registered sequencer state, consumed by the output-logic decoder.
REQ-006 SHALL have port turn_side  output  1  registered latched direction; 0 left, 1 right.
REQ-007 SHALL have port step_tick  output  1  registered one-cycle pulse marking each sequencer step.

Function
REQ-008 SHALL pass SW through a two-flop synchronizer; FSM uses only the synchronized value (2-cycle latency).
REQ-009 SHALL run a tick counter 0..TICK_DIV-1, width $clog2(TICK_DIV); step_tick high exactly in the cycle the counter equals TICK_DIV-1, then counter wraps to 0.
REQ-010 SHALL change CurrentState only on the rising edge where step_tick is 1; otherwise hold.
REQ-011 SHALL encode states IDLE=0, S1=1, S2=2, S3=3, HAZ=4; codes 5-7 unused.
REQ-012 SHALL, at a step in IDLE: exactly one synchronized request -> S1 and latch turn_side (SW[1]); none -> IDLE.
REQ-013 SHALL advance S1->S2->S3->IDLE on successive steps regardless of request level; turn_side held throughout.
REQ-014 SHALL ignore request release or direction change mid-sequence; new direction takes effect only from IDLE.
REQ-015 SHALL treat both requests set (hazard) per Configuration; hazard has priority over a single request at the same step.
REQ-016 SHALL decode any unused state code to IDLE at the next step.

Reset
REQ-017 SHALL, while Rn low, force CurrentState=0, turn_side=0, step_tick=0, tick counter=0, synchronizer flops=0.
REQ-018 SHALL release reset without glitch; first step_tick asserts TICK_DIV cycles after the first clk edge with Rn high.
REQ-019 SHALL abort any sequence or hazard on Rn assertion mid-operation, returning to IDLE immediately.

Configuration
REQ-020 SHALL support macro TURN_HAZARD_EN.
REQ-021 SHALL, with TURN_HAZARD_EN defined: both requests at a step from IDLE, S1, S2 or S3 -> HAZ; HAZ -> IDLE at next step (one-step-on/one-step-off blink while held); turn_side unchanged in HAZ.
REQ-022 SHALL, without TURN_HAZARD_EN: both requests treated as no request (IDLE stays IDLE, sequences complete normally); HAZ state and its logic absent.

Structure
REQ-023 SHALL place state encodings (IDLE, S1, S2, S3, HAZ) and the 3-bit state width constant in shared package turn_pkg, also used by the output-logic decoder.
REQ-024 SHALL implement the counter/pulse as sub-module tick_gen (params TICK_DIV; ports clk, Rn, tick).

Verification (TICK_DIV=4)
REQ-025 SHALL check reset: Rn=0 for 10 ns, SW=2'b00 -> CurrentState=0, turn_side=0, step_tick=0; first step_tick 4 cycles after release.
REQ-026 SHALL check left sequence: SW=2'b01 held -> CurrentState 0,1,2,3,0,1... on successive steps, turn_side=0.
REQ-027 SHALL check mid-sequence change: SW=2'b10 to reach S2, then SW=2'b01 -> S3, IDLE with turn_side=1, then S1 with turn_side=0.
REQ-028 SHALL check hazard (TURN_HAZARD_EN): SW=2'b11 from S1 -> CurrentState 4,0,4,0 on steps; without macro -> 2,3,0,0.
REQ-029 SHALL check synchronizer latency: SW pulse of 1 cycle, not overlapping the 2-cycle window before a step -> no state change.
REQ-030 SHALL check reset mid-sequence: Rn=0 in S2 -> CurrentState=0 within same cycle, counter restarts.
